// File: rtl/snake_game_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// snake_game_ctrl_pkg
// Shared constants and types for the snake game sequencer and its fruit placer.
//   GAME_WIDTH / GAME_HEIGHT : playfield size in cells; legal cells are 1..N
//   MAX_LENGTH               : longest body the engine can hold
//   DIR_*                    : heading encoding; a heading and its reverse
//                              differ only in bit 0
//   game_state_t             : top-level game state, visible on o_state
//   fruit_state_t            : fruit placement state
// -----------------------------------------------------------------------------
package snake_game_ctrl_pkg;

  localparam int GAME_WIDTH  = 20;
  localparam int GAME_HEIGHT = 12;
  localparam int MAX_LENGTH  = 32;

  localparam logic [1:0] DIR_RIGHT = 2'b00;
  localparam logic [1:0] DIR_LEFT  = 2'b01;
  localparam logic [1:0] DIR_DOWN  = 2'b10;
  localparam logic [1:0] DIR_UP    = 2'b11;

  typedef enum logic [1:0] {
    G_IDLE = 2'b00,
    G_RUN  = 2'b01,
    G_LOST = 2'b10,
    G_WON  = 2'b11
  } game_state_t;

  typedef enum logic [1:0] {
    F_IDLE  = 2'b00,
    F_ROLL  = 2'b01,
    F_CHECK = 2'b10
  } fruit_state_t;

  function automatic logic [1:0] reverse_dir(input logic [1:0] d);
    return d ^ 2'b01;
  endfunction

  // 16-bit Fibonacci LFSR, taps 16,15,13,4 (bits 15,14,12,3).
  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {s[14:0], s[15] ^ s[14] ^ s[12] ^ s[3]};
  endfunction

endpackage

// File: rtl/snake_game_ctrl_if.sv
// -----------------------------------------------------------------------------
// snake_game_ctrl_if
// Bus between the game sequencer (master) and the snake body engine (slave).
// Signal prefixes are from the sequencer's point of view.
//   o_snake_rst_n          engine synchronous reset, active-low
//   o_tick / o_dir         step request (held until the head moves) + heading
//   o_eat                  one-cycle grow pulse
//   o_fruit_x/y/valid      fruit cell and its placed-and-checked flag
//   i_head_x/y, i_head_dir engine head position and heading
//   i_pos_x/y, i_pos_valid continuous body scan, head first
//   i_failure / i_success  engine end-of-game flags
// -----------------------------------------------------------------------------
interface snake_game_ctrl_if;
  logic       o_snake_rst_n;
  logic       o_tick;
  logic [1:0] o_dir;
  logic       o_eat;
  logic [4:0] o_fruit_x;
  logic [3:0] o_fruit_y;
  logic       o_fruit_valid;
  logic [4:0] i_head_x;
  logic [3:0] i_head_y;
  logic [1:0] i_head_dir;
  logic [4:0] i_pos_x;
  logic [3:0] i_pos_y;
  logic       i_pos_valid;
  logic       i_failure;
  logic       i_success;

  modport master (
    output o_snake_rst_n, o_tick, o_dir, o_eat, o_fruit_x, o_fruit_y, o_fruit_valid,
    input  i_head_x, i_head_y, i_head_dir, i_pos_x, i_pos_y, i_pos_valid,
           i_failure, i_success
  );

  modport slave (
    input  o_snake_rst_n, o_tick, o_dir, o_eat, o_fruit_x, o_fruit_y, o_fruit_valid,
    output i_head_x, i_head_y, i_head_dir, i_pos_x, i_pos_y, i_pos_valid,
           i_failure, i_success
  );
endinterface

// File: rtl/snake_fruit_placer.sv
// -----------------------------------------------------------------------------
// snake_fruit_placer
// Places the fruit from a free-running LFSR and rejects cells on the body by
// watching one full body scan from the engine.
//   clk, rst        clock, asynchronous active-high reset
//   i_start         pulse: drop the current fruit and place a new one
//   i_head_x/y      engine head (scan start marker, restart on move)
//   i_pos_x/y/valid engine body scan
//   o_fruit_x/y     fruit cell (last accepted candidate)
//   o_fruit_valid   candidate survived a full scan with no body hit
// -----------------------------------------------------------------------------
module snake_fruit_placer
  import snake_game_ctrl_pkg::*;
#(
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_start,
  input  logic [4:0] i_head_x,
  input  logic [3:0] i_head_y,
  input  logic [4:0] i_pos_x,
  input  logic [3:0] i_pos_y,
  input  logic       i_pos_valid,
  output logic [4:0] o_fruit_x,
  output logic [3:0] o_fruit_y,
  output logic       o_fruit_valid
);

  fruit_state_t r_fstate, w_fnext;
  logic [15:0]  r_lfsr;
  logic [4:0]   r_fx;
  logic [3:0]   r_fy;
  logic         r_fvalid;
  logic         r_scan_on, w_scan_nxt;
  logic [4:0]   r_hx_p;
  logic [3:0]   r_hy_p;

  logic [4:0]   w_cx;
  logic [3:0]   w_cy;
  logic         w_cand_in, w_head_moved, w_at_head, w_at_cand;
  logic         w_load, w_set_valid;

  assign w_cx = r_lfsr[4:0];
  assign w_cy = r_lfsr[8:5];
  assign w_cand_in = (w_cx != 5'd0) && (w_cx <= 5'(GAME_WIDTH)) &&
                     (w_cy != 4'd0) && (w_cy <= 4'(GAME_HEIGHT));
  assign w_head_moved = (i_head_x != r_hx_p) || (i_head_y != r_hy_p);
  assign w_at_head = i_pos_valid && (i_pos_x == i_head_x) && (i_pos_y == i_head_y);
  assign w_at_cand = i_pos_valid && (i_pos_x == r_fx) && (i_pos_y == r_fy);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fstate  <= F_IDLE;
      r_lfsr    <= LFSR_SEED;
      r_fx      <= 5'd1;
      r_fy      <= 4'd1;
      r_fvalid  <= 1'b0;
      r_scan_on <= 1'b0;
      r_hx_p    <= 5'd0;
      r_hy_p    <= 4'd0;
    end else begin
      // LFSR runs in every state so the fruit depends on player timing.
      r_lfsr    <= lfsr_next(r_lfsr);
      r_fstate  <= w_fnext;
      r_scan_on <= w_scan_nxt;
      r_hx_p    <= i_head_x;
      r_hy_p    <= i_head_y;
      if (w_load) begin
        r_fx <= w_cx;
        r_fy <= w_cy;
      end
      if (i_start)          r_fvalid <= 1'b0;
      else if (w_set_valid) r_fvalid <= 1'b1;
    end
  end

  // r_scan_on marks that the scan passed the head cell; from there until
  // i_pos_valid falls every body cell has been presented exactly once.
  always_comb begin
    w_fnext     = r_fstate;
    w_scan_nxt  = r_scan_on;
    w_load      = 1'b0;
    w_set_valid = 1'b0;
    if (i_start) begin
      w_fnext    = F_ROLL;
      w_scan_nxt = 1'b0;
    end else begin
      case (r_fstate)
        F_IDLE: ;
        F_ROLL: begin
          if (w_cand_in) begin
            w_load     = 1'b1;
            w_fnext    = F_CHECK;
            w_scan_nxt = 1'b0;
          end
        end
        F_CHECK: begin
          if (w_head_moved) begin
            // Body changed under us: the partial scan is worthless.
            w_scan_nxt = 1'b0;
          end else if (!r_scan_on) begin
            if (w_at_head) begin
              if (w_at_cand) w_fnext = F_ROLL;
              else           w_scan_nxt = 1'b1;
            end
          end else if (w_at_cand) begin
            w_fnext    = F_ROLL;
            w_scan_nxt = 1'b0;
          end else if (!i_pos_valid) begin
            w_fnext     = F_IDLE;
            w_set_valid = 1'b1;
            w_scan_nxt  = 1'b0;
          end
        end
        default: w_fnext = F_IDLE;
      endcase
    end
  end

  assign o_fruit_x     = r_fx;
  assign o_fruit_y     = r_fy;
  assign o_fruit_valid = r_fvalid;

endmodule

// File: rtl/snake_game_ctrl.sv
// -----------------------------------------------------------------------------
// snake_game_ctrl
// Game sequencer for the snake body engine: game FSM, step pacing from video
// frames, direction capture with reversal rejection, eat pulse and scoring.
// Fruit placement lives in snake_fruit_placer.
//   clk, rst   clock, asynchronous active-high reset
//   i_frame    one-cycle pulse per video frame
//   i_btn      synchronised buttons, bit n requests heading n
//   bus        snake_game_ctrl_if.master towards the engine
//   o_state    00 IDLE, 01 RUN, 10 LOST, 11 WON
//   o_score    fruits eaten, saturating at 255
// Build option: define SNAKE_SPEEDUP_EN to shorten the step period by one
// frame per 4 fruits, never below MIN_TICK_FRAMES. Without it the period is
// fixed at TICK_FRAMES.
// -----------------------------------------------------------------------------
module snake_game_ctrl
  import snake_game_ctrl_pkg::*;
#(
  parameter int          TICK_FRAMES     = 8,
  parameter int          MIN_TICK_FRAMES = 2,
  parameter logic [15:0] LFSR_SEED       = 16'hACE1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_frame,
  input  logic [3:0]          i_btn,
  snake_game_ctrl_if.master   bus,
  output logic [1:0]          o_state,
  output logic [7:0]          o_score
);

  game_state_t r_state, w_state_nxt;
  logic [3:0]  r_btn_prev, w_btn_rise;
  logic        r_snake_rst_n, r_tick, r_eat;
  logic [1:0]  r_pending_dir, r_dir, w_cand_dir;
  logic [7:0]  r_score, r_frame_cnt, w_period;
  logic [4:0]  r_prev_hx;
  logic [3:0]  r_prev_hy;
  logic        w_run_active, w_start_game, w_moved, w_eat_hit, w_cand_ok;
  logic [4:0]  w_fruit_x;
  logic [3:0]  w_fruit_y;
  logic        w_fruit_valid;

  assign w_btn_rise = i_btn & ~r_btn_prev;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_btn_prev <= 4'd0;
    else     r_btn_prev <= i_btn;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= G_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      G_IDLE: if (|w_btn_rise) w_state_nxt = G_RUN;
      G_RUN: begin
        if (bus.i_failure)      w_state_nxt = G_LOST;
        else if (bus.i_success) w_state_nxt = G_WON;
      end
      G_LOST, G_WON: if (|w_btn_rise) w_state_nxt = G_IDLE;
      default: w_state_nxt = G_IDLE;
    endcase
  end

  // Pacing and eating only act while the game stays in RUN this cycle, so a
  // failure/success cycle already freezes tick and eat.
  assign w_run_active = (r_state == G_RUN) && (w_state_nxt == G_RUN);
  assign w_start_game = (r_state == G_IDLE) && (w_state_nxt == G_RUN);
  assign w_moved      = r_tick && ((bus.i_head_x != r_prev_hx) || (bus.i_head_y != r_prev_hy));
  assign w_eat_hit    = w_run_active && w_moved && w_fruit_valid &&
                        (bus.i_head_x == w_fruit_x) && (bus.i_head_y == w_fruit_y);

  // Lowest-index rising button wins; a reversal of the current heading is dropped.
  always_comb begin
    w_cand_dir = 2'd0;
    if (w_btn_rise[0])      w_cand_dir = 2'd0;
    else if (w_btn_rise[1]) w_cand_dir = 2'd1;
    else if (w_btn_rise[2]) w_cand_dir = 2'd2;
    else if (w_btn_rise[3]) w_cand_dir = 2'd3;
  end
  assign w_cand_ok = (|w_btn_rise) && !r_tick && (reverse_dir(w_cand_dir) != bus.i_head_dir);

`ifdef SNAKE_SPEEDUP_EN
  always_comb begin
    if (TICK_FRAMES - int'(r_score[7:2]) < MIN_TICK_FRAMES) w_period = 8'(MIN_TICK_FRAMES);
    else w_period = 8'(TICK_FRAMES - int'(r_score[7:2]));
  end
`else
  logic [7:0] w_unused_min;
  assign w_unused_min = 8'(MIN_TICK_FRAMES);
  assign w_period     = 8'(TICK_FRAMES);
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_snake_rst_n <= 1'b0;
      r_tick        <= 1'b0;
      r_eat         <= 1'b0;
      r_pending_dir <= 2'd0;
      r_dir         <= 2'd0;
      r_score       <= 8'd0;
      r_frame_cnt   <= 8'd0;
      r_prev_hx     <= 5'd0;
      r_prev_hy     <= 4'd0;
    end else begin
      // Engine leaves reset together with the first RUN cycle.
      r_snake_rst_n <= (w_state_nxt != G_IDLE);
      r_eat         <= w_eat_hit;
      if (w_cand_ok) r_pending_dir <= w_cand_dir;

      if (w_start_game)                         r_score <= 8'd0;
      else if (w_eat_hit && r_score != 8'hFF)   r_score <= r_score + 8'd1;

      if (!w_run_active) begin
        r_frame_cnt <= 8'd0;
        r_tick      <= 1'b0;
      end else if (r_tick) begin
        // Frames are not counted while a step is outstanding.
        if (w_moved) r_tick <= 1'b0;
      end else if (i_frame) begin
        // >= keeps the step coming if the period shrank below the count.
        if (r_frame_cnt >= (w_period - 8'd1)) begin
          r_frame_cnt <= 8'd0;
          r_tick      <= 1'b1;
          r_prev_hx   <= bus.i_head_x;
          r_prev_hy   <= bus.i_head_y;
          r_dir       <= r_pending_dir;
        end else begin
          r_frame_cnt <= r_frame_cnt + 8'd1;
        end
      end
    end
  end

  snake_fruit_placer #(
    .LFSR_SEED(LFSR_SEED)
  ) u_fruit (
    .clk          (clk),
    .rst          (rst),
    .i_start      (w_start_game | w_eat_hit),
    .i_head_x     (bus.i_head_x),
    .i_head_y     (bus.i_head_y),
    .i_pos_x      (bus.i_pos_x),
    .i_pos_y      (bus.i_pos_y),
    .i_pos_valid  (bus.i_pos_valid),
    .o_fruit_x    (w_fruit_x),
    .o_fruit_y    (w_fruit_y),
    .o_fruit_valid(w_fruit_valid)
  );

  assign bus.o_snake_rst_n = r_snake_rst_n;
  assign bus.o_tick        = r_tick;
  assign bus.o_dir         = r_dir;
  assign bus.o_eat         = r_eat;
  assign bus.o_fruit_x     = w_fruit_x;
  assign bus.o_fruit_y     = w_fruit_y;
  assign bus.o_fruit_valid = w_fruit_valid;
  assign o_state           = r_state;
  assign o_score           = r_score;

endmodule

// File: doc/snake_game_ctrl.md
Name: snake_game_ctrl

Overview:
Game sequencer for the snake body engine. Owns the game state machine, tick pacing from frame pulses, direction capture with reversal rejection, and the eat pulse. Also places the fruit with an LFSR and rejects candidates that lie on the body, using the engine's continuous body scan. Sits between the button/VGA front end and the snake engine; the engine's synchronous active-low reset is driven from here.

Parameters:
TICK_FRAMES, 8, frame pulses per snake step at score 0
MIN_TICK_FRAMES, 2, lower bound on step period (SPEEDUP_EN only)
LFSR_SEED, 16'hACE1, nonzero reset value of the 16-bit Fibonacci LFSR (taps 16,15,13,4)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-high
i_frame  in  1  one-cycle pulse per video frame
i_btn  in  4  synchronised buttons [0]=dir 00,[1]=01,[2]=10,[3]=11
i_head_x/i_head_y  in  5/4  engine head position
i_head_dir  in  2  engine current heading
i_pos_x/i_pos_y  in  5/4  engine scan position
i_pos_valid  in  1  scan position is a body cell
i_failure/i_success  in  1  engine flags
o_snake_rst_n  out  1  engine synchronous reset, active-low
o_tick  out  1  step request, held until accepted
o_dir  out  2  requested heading, stable while o_tick=1
o_eat  out  1  one-cycle grow pulse
o_fruit_x/o_fruit_y  out  5/4  fruit cell
o_fruit_valid  out  1  fruit placed and checked
o_state  out  2  00 IDLE,01 RUN,10 LOST,11 WON
o_score  out  8  fruits eaten, saturating at 255

Behaviour:
- Reset values: state IDLE, o_snake_rst_n=0, o_tick=0, o_dir=0, o_eat=0, fruit=(1,1), o_fruit_valid=0, o_score=0, LFSR=LFSR_SEED, frame counter 0.
- LFSR advances every clock in all states (entropy from player timing).
- IDLE: o_snake_rst_n=0; any i_btn bit rising (0->1 vs previous cycle) -> RUN, start fruit placement; o_snake_rst_n=1 from the next cycle.
- RUN: frame counter increments on i_frame; at count==period-1, clears and sets o_tick=1, captures prev_head=(i_head_x,i_head_y). o_tick clears the cycle after head differs from prev_head (engine moved). Frame pulses while o_tick=1 are ignored (no count).
- Direction: pending_dir updated on any button rising edge when o_tick=0; lowest index wins if several rise together. Candidate d rejected when d^2'b01==i_head_dir (reversal). o_dir=pending_dir, latched at tick assert.
- Eat: the cycle after head-move detection, if fruit_valid and head==fruit: o_eat=1 for exactly one cycle, o_score+1 (saturating), fruit_valid=0, start placement.
- RUN->LOST on i_failure=1 in any cycle; RUN->WON on i_success=1; failure wins if both. LOST/WON freeze o_tick=0, o_eat=0, score kept; button rising edge -> IDLE (one cycle engine reset), then IDLE rules.
- Fruit FSM: F_IDLE, F_ROLL, F_CHECK. F_ROLL: candidate x=lfsr[4:0], y=lfsr[8:5]; accept into F_CHECK only if 1<=x<=GAME_WIDTH and 1<=y<=GAME_HEIGHT, else retry next cycle. F_CHECK: wait for scan start (i_pos_valid with pos at head: i_pos_x/y==head), then over one full scan any i_pos_valid cell equal to candidate -> F_ROLL; scan ends when i_pos_valid falls with no hit -> fruit_valid=1, F_IDLE. Head moving during F_CHECK restarts the check.
- Reset mid-operation: async rst returns all state above immediately; engine held in reset.

Optional Feature:
SNAKE_SPEEDUP_EN: defined -> period = max(MIN_TICK_FRAMES, TICK_FRAMES - o_score[7:2]) (one frame faster per 4 fruits). Undefined -> period fixed at TICK_FRAMES; MIN_TICK_FRAMES unused.

Decomposition:
- Shared package: GAME_WIDTH, GAME_HEIGHT, MAX_LENGTH, dir encoding constants, game-state and fruit-state enums.
- One sub-module: snake_fruit_placer (LFSR, fruit FSM, body-collision check); top holds game FSM, pacing, direction, eat.

Test Plan:
- Reset, press i_btn[2] -> state RUN, o_snake_rst_n=1 next cycle, o_fruit_valid=1 within 2 scans, fruit inside 1..GAME_WIDTH x 1..GAME_HEIGHT.
- 8 i_frame pulses in RUN -> o_tick asserts after 8th, drops one cycle after head moves; 9th pulse while pending not counted.
- Heading 10, press i_btn[3] -> o_dir stays 10; press i_btn[0] -> o_dir=00 at next tick.
- Force fruit onto head's next cell -> single-cycle o_eat, o_score=1, fruit re-placed not on any body cell (model-checked over 1000 placements).
- Drive into wall -> i_failure -> LOST, o_tick=0; button press -> one IDLE cycle with o_snake_rst_n=0, then RUN with o_score=0.
- SNAKE_SPEEDUP_EN, o_score=24 -> period 2 frames (clamped to MIN_TICK_FRAMES); undefined -> 8.
